regs_dump: RTL

Debug read-out engine for the picoMIPS register file. On a start request it takes over the register file's read port 1, walks addresses 0 to LAST, and captures each register. Each value goes out as one beat on a valid/ready stream toward the debug/trace link. While it runs it asserts `hold`, which the core uses to suppress register writes so the snapshot is coherent.

---
 rtl/regs_dump.sv | 110 +++++++++++
 1 files changed

// File: rtl/regs_dump.sv
`default_nettype none
// ============================================================================
//  Module      : regs_dump
//  Description : Debug read-out engine for the picoMIPS register file. On a
//                start request it borrows register-file read port 1, walks
//                addresses 0..LAST and emits each register as one beat on a
//                valid/ready stream. hold (== busy) freezes core register
//                writes so the snapshot is coherent.
//  Revision    : 1.0 - initial release
// ============================================================================
module regs_dump #(
    parameter int n    = 8,
    parameter int LAST = 13
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic [3:0]   Raddr,
    input  logic [n-1:0] Rdata,
    output logic [n-1:0] out_data,
    output logic [3:0]   out_addr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         hold,
    output logic         done
);

    localparam logic [3:0] C_LAST = 4'(LAST);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t       r_state;
    logic [3:0]   r_addr;
    logic [n-1:0] r_data;
    logic [3:0]   r_out_addr;
    logic         r_valid;
    logic         r_busy;
    logic         r_done;

    // Dump sequencer: busy/done are registered alongside the state so that
    // they never glitch on multi-bit state transitions (e.g. SEND -> READ).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_addr     <= 4'd0;
            r_data     <= '0;
            r_out_addr <= 4'd0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_addr <= 4'd0;
                    if (start) begin
                        r_state <= S_READ;
                        r_busy  <= 1'b1;
                    end
                end
                S_READ: begin
                    // Core is held, so Rdata for r_addr is stable this cycle.
                    r_data     <= Rdata;
                    r_out_addr <= r_addr;
                    r_valid    <= 1'b1;
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    if (r_valid && out_ready) begin
                        r_valid <= 1'b0;
                        if (r_addr == C_LAST) begin
                            // Counter stops at LAST, so it never wraps.
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_addr  <= r_addr + 4'd1;
                            r_state <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    r_addr  <= 4'd0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign Raddr     = r_addr;
    assign out_data  = r_data;
    assign out_addr  = r_out_addr;
    assign out_valid = r_valid;
    assign busy      = r_busy;
    assign hold      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire
